// File: rtl/desc_pkg.sv
// Shared definitions for the descriptor fetch engine.
//   descriptor_t            : packed descriptor as stored in descriptor memory
//                             {src_address[15:0], dst_address[15:0], payload_ptr[31:0]}
//   NUM_DESCRIPTORS_DEFAULT : default number of descriptor slots
//   fetch_state_e           : fetch FSM state encoding
package desc_pkg;

   localparam int unsigned NUM_DESCRIPTORS_DEFAULT = 16;

   typedef struct packed {
      logic [15:0] src_address;
      logic [15:0] dst_address;
      logic [31:0] payload_ptr;
   } descriptor_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WAIT,
      ST_PRESENT,
      ST_DONE
   } fetch_state_e;

endpackage

// File: rtl/descriptor_fetch.sv
// Descriptor fetch engine: reads a run of consecutive descriptor slots
// (wrapping at NUM_DESCRIPTORS) from a synchronous-read memory and presents
// each one downstream with a valid/ready handshake.
//
// Ports
//   clk_i, rst_i            : clock, synchronous active-high reset
//   start_i                 : one-cycle run request (ignored while busy_o)
//   first_idx_i, count_i    : first slot and descriptor count (clamped)
//   busy_o, done_o          : run active / one-cycle end-of-run pulse
//   mem_addr_o, mem_rd_en_o : memory slot address and read strobe
//   mem_*_i                 : memory read data, valid one cycle after strobe
//   desc_valid_o/ready_i    : downstream handshake
//   desc_*_o, desc_idx_o    : registered descriptor fields and slot index
module descriptor_fetch
   import desc_pkg::*;
#(
   parameter int unsigned NUM_DESCRIPTORS = NUM_DESCRIPTORS_DEFAULT,
   parameter int unsigned IDX_W           = $clog2(NUM_DESCRIPTORS)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [IDX_W-1:0] first_idx_i,
   input  logic [IDX_W:0]   count_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [IDX_W-1:0] mem_addr_o,
   output logic             mem_rd_en_o,
   input  logic [15:0]      mem_src_address_i,
   input  logic [15:0]      mem_dst_address_i,
   input  logic [31:0]      mem_payload_ptr_i,
   output logic             desc_valid_o,
   input  logic             desc_ready_i,
   output logic [15:0]      desc_src_address_o,
   output logic [15:0]      desc_dst_address_o,
   output logic [31:0]      desc_payload_ptr_o,
   output logic [IDX_W-1:0] desc_idx_o
);

   localparam logic [IDX_W:0]   CNT_MAX  = (IDX_W+1)'(NUM_DESCRIPTORS);
   localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DESCRIPTORS - 1);

   fetch_state_e     state_q, state_d;
   logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
   logic [IDX_W:0]   remaining_q, remaining_d;
   logic [IDX_W-1:0] mem_addr_q, mem_addr_d;
   descriptor_t      desc_q, desc_d;
   logic [IDX_W-1:0] desc_idx_q, desc_idx_d;

   logic [IDX_W:0]   count_clamped;
   logic [IDX_W-1:0] next_idx;

   assign count_clamped = (count_i > CNT_MAX) ? CNT_MAX : count_i;
   // Explicit wrap so non-power-of-two slot counts also return to slot 0.
   assign next_idx      = (cur_idx_q == IDX_LAST) ? '0 : cur_idx_q + IDX_W'(1);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         cur_idx_q   <= '0;
         remaining_q <= '0;
         mem_addr_q  <= '0;
         desc_q      <= '0;
         desc_idx_q  <= '0;
      end else begin
         state_q     <= state_d;
         cur_idx_q   <= cur_idx_d;
         remaining_q <= remaining_d;
         mem_addr_q  <= mem_addr_d;
         desc_q      <= desc_d;
         desc_idx_q  <= desc_idx_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cur_idx_d   = cur_idx_q;
      remaining_d = remaining_q;
      mem_addr_d  = mem_addr_q;
      desc_d      = desc_q;
      desc_idx_d  = desc_idx_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               if (count_i == '0) begin
                  state_d = ST_DONE;
               end else begin
                  cur_idx_d   = first_idx_i;
                  remaining_d = count_clamped;
                  // Address register is loaded on entry to READ so it is
                  // already valid during the strobe cycle and holds afterwards.
                  mem_addr_d  = first_idx_i;
                  state_d     = ST_READ;
               end
            end
         end
         ST_READ: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            desc_d.src_address = mem_src_address_i;
            desc_d.dst_address = mem_dst_address_i;
            desc_d.payload_ptr = mem_payload_ptr_i;
            desc_idx_d         = cur_idx_q;
            state_d            = ST_PRESENT;
         end
         ST_PRESENT: begin
            if (desc_ready_i) begin
               remaining_d = remaining_q - CNT_ONE;
               cur_idx_d   = next_idx;
               if (remaining_q == CNT_ONE) begin
                  state_d = ST_DONE;
               end else begin
                  mem_addr_d = next_idx;
                  state_d    = ST_READ;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy_o             = (state_q != ST_IDLE);
   assign done_o             = (state_q == ST_DONE);
   assign mem_rd_en_o        = (state_q == ST_READ);
   assign desc_valid_o       = (state_q == ST_PRESENT);
   assign mem_addr_o         = mem_addr_q;
   assign desc_src_address_o = desc_q.src_address;
   assign desc_dst_address_o = desc_q.dst_address;
   assign desc_payload_ptr_o = desc_q.payload_ptr;
   assign desc_idx_o         = desc_idx_q;

endmodule

// File: doc/descriptor_fetch.md
DESCRIPTOR_FETCH -- requirements
Module: descriptor_fetch

Interface
REQ-001 SHALL have parameter NUM_DESCRIPTORS, default 16, meaning the number of descriptor slots in the attached descriptor memory; IDX_W = $clog2(NUM_DESCRIPTORS), default 4.
REQ-002 SHALL use one clock and a synchronous, active-high reset.
REQ-003 clk_i  input  1  single clock; all logic on the rising edge.
REQ-004 rst_i  input  1  synchronous active-high reset.
REQ-005 start_i  input  1  one-cycle request to begin a fetch run.
REQ-006 first_idx_i  input  IDX_W  first descriptor slot of the run.
REQ-007 count_i  input  IDX_W+1  number of descriptors to fetch, 0..NUM_DESCRIPTORS.
REQ-008 busy_o  output  1  high while a run is active.
REQ-009 done_o  output  1  one-cycle pulse at the end of a run.
REQ-010 mem_addr_o  output  IDX_W  slot address driven to the descriptor memory.
REQ-011 mem_rd_en_o  output  1  read strobe to the memory.
REQ-012 mem_src_address_i / mem_dst_address_i / mem_payload_ptr_i  input  16/16/32  memory read data.
REQ-013 desc_valid_o  output  1  descriptor presented downstream.
REQ-014 desc_ready_i  input  1  downstream accepts the descriptor.
REQ-015 desc_src_address_o / desc_dst_address_o / desc_payload_ptr_o  output  16/16/32  registered descriptor fields.
REQ-016 desc_idx_o  output  IDX_W  slot index of the presented descriptor.

Function
REQ-017 SHALL implement the FSM IDLE -> READ -> WAIT -> PRESENT -> (READ | DONE) -> IDLE.
REQ-018 IDLE: on start_i with count_i>0, SHALL latch first_idx_i into cur_idx and count_i into remaining, then enter READ; with count_i==0, SHALL enter DONE directly.
REQ-019 READ: for exactly one cycle, SHALL drive mem_rd_en_o=1 and mem_addr_o=cur_idx; next state WAIT.
REQ-020 WAIT: SHALL capture the memory data, which is valid one cycle after the read strobe, into the desc_* registers, set desc_idx_o=cur_idx, and enter PRESENT.
REQ-021 PRESENT: desc_valid_o=1; the desc_* outputs SHALL hold stable until desc_valid_o && desc_ready_i.
REQ-022 On the PRESENT handshake, SHALL decrement remaining and advance cur_idx = (cur_idx+1) mod NUM_DESCRIPTORS; if remaining was 1, enter DONE, else enter READ.
REQ-023 Index wrap: slot NUM_DESCRIPTORS-1 SHALL be followed by slot 0.
REQ-024 DONE: done_o=1 for exactly one cycle; next state IDLE.
REQ-025 busy_o SHALL be 1 in READ, WAIT, PRESENT and DONE, and 0 in IDLE.
REQ-026 start_i asserted while busy_o=1 SHALL be ignored, with no effect on the run.
REQ-027 count_i values greater than NUM_DESCRIPTORS SHALL be clamped to NUM_DESCRIPTORS.
REQ-028 Throughput SHALL be one descriptor per 3 cycles when desc_ready_i is held high; desc_ready_i low in PRESENT stalls the run indefinitely.
REQ-029 mem_rd_en_o SHALL be 0 outside READ; mem_addr_o SHALL hold its last value outside READ.

Reset
REQ-030 rst_i=1 SHALL force state IDLE, busy_o=0, done_o=0, desc_valid_o=0, mem_rd_en_o=0, mem_addr_o=0, desc_*=0, desc_idx_o=0.
REQ-031 Reset asserted mid-run (in any state) SHALL abort the run on the next edge with no done_o pulse, and any presented descriptor SHALL be dropped.
REQ-032 Reset SHALL take priority over start_i and desc_ready_i in the same cycle.

Structure
REQ-033 Shared package desc_pkg SHALL hold descriptor_t (packed: src_address 16, dst_address 16, payload_ptr 32), the NUM_DESCRIPTORS default, and the FSM state enum.
REQ-034 The block SHALL have no sub-module; the descriptor memory SHALL be instantiated only in the bench as the fetch target.

Verification
REQ-035 Single fetch: memory slot 0 = 64'h1234_5678_9ABC_DEF0; start first_idx=0, count=1, ready=1 -> desc_src=16'h1234, desc_dst=16'h5678, desc_payload=32'h9ABC_DEF0, desc_idx=0, done_o pulse 4 cycles after start.
REQ-036 Multi fetch: slots 1..3 preloaded; start first_idx=1, count=3 -> three handshakes in index order 1,2,3 with matching fields, then one done_o pulse.
REQ-037 Wrap: start first_idx=15, count=2 -> desc_idx sequence 15, 0.
REQ-038 Back-pressure: hold ready=0 for 5 cycles in PRESENT -> desc_* outputs stable and no read strobe; after ready=1, the run resumes.
REQ-039 Edge cases: count=0 -> done_o pulse with no desc_valid_o; start_i pulsed while busy -> ignored.
REQ-040 Reset mid-run: rst_i asserted in PRESENT -> next cycle busy_o=0, desc_valid_o=0, all outputs 0, no done_o.
